vrased_reset_seq: RTL and testbench

Reset sequencer for the VRASED hardware monitor. It sits between the per-property monitors (X_stack, AC, atomicity, dma_AC, dma_detect, dma_X_stack, proof_reset) and the MCU reset input, in place of a plain OR of their reset requests. On any violation it asserts a reset of guaranteed minimum width, and holds it until the core is parked at the reset handler. It also keeps a sticky first-cause bitmap, a last-event cause bitmap and a saturating violation counter for post-mortem and debug.

---
 rtl/vrased_reset_seq_if.sv | 23 ++
 rtl/vrased_reset_seq.sv | 116 +++++++++++
 tb/tb_vrased_reset_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vrased_reset_seq_if.sv
// rtl/vrased_reset_seq_if.sv - monitor/MCU-facing signal bundle of the VRASED reset sequencer
interface vrased_reset_seq_if #(
  parameter int NUM_SRC = 7,
  parameter int CNT_W   = 8
);
  logic [15:0]        pc;
  logic [NUM_SRC-1:0] viol;
  logic               cause_clr;
  logic               reset;
  logic [NUM_SRC-1:0] first_cause;
  logic [NUM_SRC-1:0] last_cause;
  logic [CNT_W-1:0]   viol_cnt;

  modport master (
    output pc, viol, cause_clr,
    input  reset, first_cause, last_cause, viol_cnt
  );

  modport slave (
    input  pc, viol, cause_clr,
    output reset, first_cause, last_cause, viol_cnt
  );
endinterface

// File: rtl/vrased_reset_seq.sv
// rtl/vrased_reset_seq.sv - VRASED reset sequencer: minimum-width reset held until the core
// reaches the reset handler, with first/last cause capture and a saturating episode counter
module vrased_reset_seq #(
  parameter int          NUM_SRC       = 7,
  parameter int          HOLD_CYCLES   = 4,
  parameter int          CNT_W         = 8,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  vrased_reset_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_WAIT_PC = 2'd2
  } state_e;

  localparam int                 HC_W        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]    HOLD_RELOAD = HC_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

  state_e             state_q, state_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic               reset_q, reset_d;
  logic [NUM_SRC-1:0] first_cause_q, first_cause_d;
  logic [NUM_SRC-1:0] last_cause_q, last_cause_d;
  logic [CNT_W-1:0]   viol_cnt_q, viol_cnt_d;
  logic               viol_any;

  assign viol_any = |bus.viol;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    first_cause_d = first_cause_q;
    last_cause_d  = last_cause_q;
    viol_cnt_d    = viol_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (viol_any) begin
          state_d      = ST_HOLD;
          hold_cnt_d   = HOLD_RELOAD;
          last_cause_d = bus.viol;
          // A same-cycle clear is applied before the capture, so this event becomes the first cause.
          if (bus.cause_clr || (first_cause_q == '0)) begin
            first_cause_d = bus.viol;
          end
          if (bus.cause_clr) begin
            viol_cnt_d = CNT_ONE;
          end else if (viol_cnt_q != CNT_MAX) begin
            viol_cnt_d = viol_cnt_q + CNT_ONE;
          end
        end else if (bus.cause_clr) begin
          first_cause_d = '0;
          viol_cnt_d    = '0;
        end
      end

      ST_HOLD: begin
        last_cause_d = last_cause_q | bus.viol;
        if (viol_any) begin
          hold_cnt_d = HOLD_RELOAD;
        end else if (hold_cnt_q == '0) begin
          state_d = ST_WAIT_PC;
        end else begin
          hold_cnt_d = hold_cnt_q - HC_W'(1);
        end
      end

      ST_WAIT_PC: begin
        last_cause_d = last_cause_q | bus.viol;
        // No timeout: the core must be parked at the handler before release.
        if (viol_any) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_RELOAD;
        end else if (bus.pc == RESET_HANDLER) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    reset_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      reset_q       <= 1'b0;
      first_cause_q <= '0;
      last_cause_q  <= '0;
      viol_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      reset_q       <= reset_d;
      first_cause_q <= first_cause_d;
      last_cause_q  <= last_cause_d;
      viol_cnt_q    <= viol_cnt_d;
    end
  end

  assign bus.reset       = reset_q;
  assign bus.first_cause = first_cause_q;
  assign bus.last_cause  = last_cause_q;
  assign bus.viol_cnt    = viol_cnt_q;

endmodule

// File: tb/tb_vrased_reset_seq.sv
// tb/tb_vrased_reset_seq.sv - directed vector bench for vrased_reset_seq
module tb_vrased_reset_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vrased_reset_seq_if #(.NUM_SRC(7), .CNT_W(8)) m_if ();
  vrased_reset_seq_if #(.NUM_SRC(7), .CNT_W(2)) s_if ();

  vrased_reset_seq #(.NUM_SRC(7), .HOLD_CYCLES(4), .CNT_W(8), .RESET_HANDLER(16'h0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  vrased_reset_seq #(.NUM_SRC(7), .HOLD_CYCLES(4), .CNT_W(2), .RESET_HANDLER(16'h0000)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic [6:0]  viol;
    logic        clr;
    logic        exp_reset;
    logic [6:0]  exp_first;
    logic [6:0]  exp_last;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic [15:0] p, input logic [6:0] v, input logic c,
                     input logic er, input logic [6:0] ef, input logic [6:0] el, input logic [7:0] ec);
    vec_t t;
    t.rst = r; t.pc = p; t.viol = v; t.clr = c;
    t.exp_reset = er; t.exp_first = ef; t.exp_last = el; t.exp_cnt = ec;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic er, input logic [6:0] ef,
                     input logic [6:0] el, input logic [7:0] ec);
    n_vec++;
    if (m_if.reset !== er || m_if.first_cause !== ef || m_if.last_cause !== el || m_if.viol_cnt !== ec) begin
      n_err++;
      $display("FAIL %s: got reset=%0b first=%h last=%h cnt=%0d, want reset=%0b first=%h last=%h cnt=%0d",
               name, m_if.reset, m_if.first_cause, m_if.last_cause, m_if.viol_cnt, er, ef, el, ec);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m_if.pc = '0; m_if.viol = '0; m_if.cause_clr = 1'b0;
    s_if.pc = '0; s_if.viol = '0; s_if.cause_clr = 1'b0;

    add(1, 16'h0, 7'h00, 0, 0, 7'h00, 7'h00, 0);
    // single event
    add(0, 16'h0, 7'h02, 0, 1, 7'h02, 7'h02, 1);
    for (int i = 0; i < 4; i++) add(0, 16'h0, 7'h00, 0, 1, 7'h02, 7'h02, 1);
    add(0, 16'h0, 7'h00, 0, 0, 7'h02, 7'h02, 1);
    add(0, 16'h0, 7'h00, 0, 0, 7'h02, 7'h02, 1);
    // clear in IDLE, last_cause untouched
    add(0, 16'h0, 7'h00, 1, 0, 7'h00, 7'h02, 0);
    // overlap: reload in HOLD
    add(0, 16'h0, 7'h04, 0, 1, 7'h04, 7'h04, 1);
    add(0, 16'h0, 7'h00, 0, 1, 7'h04, 7'h04, 1);
    add(0, 16'h0, 7'h00, 0, 1, 7'h04, 7'h04, 1);
    add(0, 16'h0, 7'h10, 0, 1, 7'h04, 7'h14, 1);
    for (int i = 0; i < 4; i++) add(0, 16'h0, 7'h00, 0, 1, 7'h04, 7'h14, 1);
    add(0, 16'h0, 7'h00, 0, 0, 7'h04, 7'h14, 1);
    // second episode: first_cause sticky, counter increments
    add(0, 16'h0, 7'h01, 0, 1, 7'h04, 7'h01, 2);
    for (int i = 0; i < 4; i++) add(0, 16'h0, 7'h00, 0, 1, 7'h04, 7'h01, 2);
    add(0, 16'h0, 7'h00, 0, 0, 7'h04, 7'h01, 2);
    // clear together with event: event wins; clear ignored in HOLD
    add(0, 16'h0, 7'h40, 1, 1, 7'h40, 7'h40, 1);
    add(0, 16'h0, 7'h00, 1, 1, 7'h40, 7'h40, 1);
    add(0, 16'h0, 7'h00, 0, 1, 7'h40, 7'h40, 1);
    add(0, 16'h0, 7'h00, 0, 1, 7'h40, 7'h40, 1);
    add(0, 16'h0, 7'h00, 0, 1, 7'h40, 7'h40, 1);
    // WAIT_PC with pc away from handler, then violation restarts HOLD
    add(0, 16'hA010, 7'h00, 0, 1, 7'h40, 7'h40, 1);
    add(0, 16'hA010, 7'h00, 0, 1, 7'h40, 7'h40, 1);
    add(0, 16'hA010, 7'h08, 0, 1, 7'h40, 7'h48, 1);
    for (int i = 0; i < 4; i++) add(0, 16'hA010, 7'h00, 0, 1, 7'h40, 7'h48, 1);
    add(0, 16'h0, 7'h00, 0, 0, 7'h40, 7'h48, 1);
    // back-to-back episode, then rst mid-episode
    add(0, 16'h0, 7'h20, 0, 1, 7'h40, 7'h20, 2);
    add(1, 16'h0, 7'h00, 0, 0, 7'h00, 7'h00, 0);
    add(0, 16'h0, 7'h00, 0, 0, 7'h00, 7'h00, 0);
    add(0, 16'h0, 7'h04, 0, 1, 7'h04, 7'h04, 1);
    for (int i = 0; i < 4; i++) add(0, 16'h0, 7'h00, 0, 1, 7'h04, 7'h04, 1);
    add(0, 16'h0, 7'h00, 0, 0, 7'h04, 7'h04, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      m_if.pc = vecs[i].pc;
      m_if.viol = vecs[i].viol;
      m_if.cause_clr = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].exp_reset, vecs[i].exp_first, vecs[i].exp_last, vecs[i].exp_cnt);
    end

    // wait for pc: pc parked at 16'hA010 through cycle 11, handler reached at cycle 12
    m_if.cause_clr = 1'b0;
    for (int c = 0; c < 15; c++) begin
      m_if.viol = (c == 0) ? 7'h02 : 7'h00;
      m_if.pc   = (c < 12) ? 16'hA010 : 16'h0000;
      tick();
      n_vec++;
      if (m_if.reset !== (c < 12)) begin
        n_err++;
        $display("FAIL wait_pc cycle %0d: reset got %0b want %0b", c + 1, m_if.reset, (c < 12));
      end
    end
    chk("wait_pc_final", 0, 7'h04, 7'h02, 2);

    // saturation on the 2-bit counter instance
    for (int ep = 0; ep < 5; ep++) begin
      int guard;
      logic [6:0] v;
      logic [1:0] want_cnt;
      v = 7'(1 << ep);
      want_cnt = (ep >= 2) ? 2'd3 : 2'(ep + 1);
      s_if.viol = v;
      tick();
      s_if.viol = 7'h00;
      guard = 0;
      while (s_if.reset === 1'b1 && guard < 20) begin
        tick();
        guard++;
      end
      n_vec++;
      if (guard >= 20 || s_if.viol_cnt !== want_cnt || s_if.first_cause !== 7'h01 || s_if.last_cause !== v) begin
        n_err++;
        $display("FAIL sat ep%0d: got cnt=%0d first=%h last=%h guard=%0d, want cnt=%0d first=01 last=%h",
                 ep, s_if.viol_cnt, s_if.first_cause, s_if.last_cause, guard, want_cnt, v);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
